fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the PC register and the instruction-memory fetch handshake for the RISC-V core front end.
- Issues fetch requests at the current PC and holds fetched instructions in a one-entry output slot for decode.
- Honours hazard stalls from decode.
- Applies branch/jump/jalr redirects from execute, flushing the wrong-path instruction and inserting one refill bubble.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, value shown on if_instr_o when the slot is empty or after reset (addi x0,x0,0)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-high
stall_i  in  1  decode stall; slot is held while high
redir_valid_i  in  1  execute requests PC redirect (taken branch, jal, jalr)
redir_pc_i  in  32  redirect target
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address (= pc_o)
imem_ack_i  in  1  memory returns data this cycle
imem_rdata_i  in  32  fetched instruction, valid with ack
pc_o  out  32  current fetch PC
if_valid_o  out  1  output slot holds a valid instruction
if_pc_o  out  32  PC of the slot instruction
if_instr_o  out  32  slot instruction
flush_o  out  1  one-cycle pulse: younger pipeline stages discard contents

Behaviour:
- Reset (rstn=1, async): state=BOOT, pc_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_instr_o=NOP_INSTR, flush_o=0, imem_req_o=0.
- States: BOOT, RUN, REDIRECT. All outputs are registered except imem_req_o and imem_addr_o.
- Memory protocol:
  - imem_ack_i is legal only in a cycle with imem_req_o=1; ack while req=0 is ignored.
  - The request may be withdrawn before ack without side effects.
  - Zero-wait memory acks in the same cycle as req, giving one instruction per cycle.
- BOOT: req=0 for one cycle, then RUN.
- RUN:
  - imem_req_o = !(if_valid_o && stall_i), i.e. no fetch while the slot is full and stalled.
  - Ack: if_instr_o<=imem_rdata_i, if_pc_o<=pc_o, if_valid_o<=1, pc_o<=pc_o+4.
  - No ack and slot consumed (if_valid_o && !stall_i): if_valid_o<=0, if_instr_o<=NOP_INSTR.
  - Slot full and stalled: all slot registers and pc_o hold.
- Redirect (redir_valid_i=1, any state except BOOT, highest priority, overrides stall_i and any same-cycle ack):
  - pc_o<=redir_pc_i with bits [1:0] forced to 00.
  - if_valid_o<=0, if_instr_o<=NOP_INSTR, flush_o<=1 for exactly the next cycle.
  - state<=REDIRECT; the same-cycle ack data is discarded.
- REDIRECT: req=0 for one bubble cycle, then RUN.
  - A new redirect while in REDIRECT loads the new target, pulses flush_o again and stays in REDIRECT for one more cycle.
- Redirect during BOOT is ignored.
- pc_o arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Reset asserted mid-fetch drops req immediately and returns all outputs to reset values. An outstanding ack is ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs fetch_cnt_o[31:0] and redir_cnt_o[31:0].
  - fetch_cnt_o increments on every accepted ack (req && ack && !redir_valid_i).
  - redir_cnt_o increments on every applied redirect.
  - Both counters wrap at 2^32 and reset to 0.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, zero-wait memory ack every req -> BOOT bubble, then if_pc_o = 0x0, 0x4, 0x8 on consecutive cycles, if_valid_o=1 continuously.
- stall_i=1 for 3 cycles with slot holding pc 0x8 -> imem_req_o=0, if_pc_o stays 0x8, pc_o stays 0xC. After release, fetch resumes at 0xC.
- redir_valid_i with redir_pc_i=0x0000_0103 together with an ack -> ack discarded, flush_o=1 next cycle, if_valid_o=0, one bubble, next fetch address 0x0000_0100.
- Back-to-back redirects to 0x40 then 0x80 -> two flush pulses, first fetch after bubble at 0x80.
- pc_o=0xFFFF_FFFC, ack -> pc_o=0x0000_0000. With FETCH_PERF_EN, fetch_cnt_o advances by 1 per ack and redir_cnt_o counts exactly 2 after the previous scenario.
- Assert rstn mid-stream with req high and ack pending -> imem_req_o=0 immediately, pc_o=RESET_PC, if_instr_o=0x0000_0013, and BOOT is re-entered on release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// PC sequencing and instruction-fetch handshake for the core front end.
// Optional macro FETCH_PERF_EN adds fetch/redirect event counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        flush_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] redir_cnt_o
`endif
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        REDIRECT
    } state_t;

    state_t state;
    logic   fetch_ok;
    logic   redir_take;

    // Request is only raised in RUN, so reset (which forces BOOT) drops it at once.
    always_comb begin
        imem_req_o  = (state == RUN) && !(if_valid_o && stall_i);
        imem_addr_o = pc_o;
        fetch_ok    = imem_req_o && imem_ack_i;
        redir_take  = redir_valid_i && (state != BOOT);
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state      <= BOOT;
            pc_o       <= RESET_PC;
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_instr_o <= NOP_INSTR;
            flush_o    <= 1'b0;
        end else begin
            flush_o <= 1'b0;
            case (state)
                BOOT: state <= RUN;
                default: begin
                    if (redir_valid_i) begin
                        // Redirect wins over stall and discards any same-cycle ack.
                        state      <= REDIRECT;
                        pc_o       <= {redir_pc_i[31:2], 2'b00};
                        if_valid_o <= 1'b0;
                        if_instr_o <= NOP_INSTR;
                        flush_o    <= 1'b1;
                    end else if (state == REDIRECT) begin
                        state <= RUN;
                    end else if (fetch_ok) begin
                        if_instr_o <= imem_rdata_i;
                        if_pc_o    <= pc_o;
                        if_valid_o <= 1'b1;
                        pc_o       <= pc_o + 32'd4;
                    end else if (if_valid_o && !stall_i) begin
                        if_valid_o <= 1'b0;
                        if_instr_o <= NOP_INSTR;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            fetch_cnt_o <= '0;
            redir_cnt_o <= '0;
        end else begin
            if (fetch_ok && !redir_valid_i) fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (redir_take)                 redir_cnt_o <= redir_cnt_o + 32'd1;
        end
    end
`else
    logic unused_redir_take;
    always_comb unused_redir_take = redir_take;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus randomized run against a reference model.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        stall_i = 1'b0;
    logic        redir_valid_i = 1'b0;
    logic [31:0] redir_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] pc_o;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        flush_o;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] redir_cnt_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rstn(rstn), .stall_i(stall_i),
        .redir_valid_i(redir_valid_i), .redir_pc_i(redir_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .pc_o(pc_o), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
        .if_instr_o(if_instr_o), .flush_o(flush_o)
`ifdef FETCH_PERF_EN
        , .fetch_cnt_o(fetch_cnt_o), .redir_cnt_o(redir_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: slot contents plus "cycles the front end must idle" bookkeeping.
    logic [31:0] m_pc, m_ipc, m_instr;
    logic        m_valid, m_flush;
    bit          m_booting, m_bubble;
    logic [31:0] m_fcnt, m_rcnt;

    function automatic bit m_req();
        return !m_booting && !m_bubble && !(m_valid && stall_i);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0; m_flush = 1'b0;
        m_booting = 1'b1; m_bubble = 1'b0; m_fcnt = 32'h0; m_rcnt = 32'h0;
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rp,
                         input logic a, input logic [31:0] d);
        @(negedge clk);
        stall_i = s; redir_valid_i = r; redir_pc_i = rp; imem_ack_i = a; imem_rdata_i = d;
        #1;
    endtask

    task automatic tick();
        bit accepted;
        @(posedge clk);
        accepted = m_req() && imem_ack_i;
        if (rstn) begin
            model_reset();
        end else if (m_booting) begin
            m_booting = 1'b0; m_flush = 1'b0;
        end else if (redir_valid_i) begin
            m_pc = redir_pc_i & 32'hFFFF_FFFC; m_valid = 1'b0; m_instr = NOP;
            m_flush = 1'b1; m_bubble = 1'b1; m_rcnt = m_rcnt + 1;
        end else if (m_bubble) begin
            m_bubble = 1'b0; m_flush = 1'b0;
        end else begin
            m_flush = 1'b0;
            if (accepted) begin
                m_instr = imem_rdata_i; m_ipc = m_pc; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_fcnt = m_fcnt + 1;
            end else if (m_valid && !stall_i) begin
                m_valid = 1'b0; m_instr = NOP;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b exp 0", imem_req_o); end
        vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h exp 00000000", pc_o); end
        vectors++; if (if_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b exp 0", if_valid_o); end
        vectors++; if (if_pc_o !== 32'h0) begin miscompares++; $display("FAIL reset_ifpc: got %h exp 00000000", if_pc_o); end
        vectors++; if (if_instr_o !== NOP) begin miscompares++; $display("FAIL reset_instr: got %h exp %h", if_instr_o, NOP); end
        vectors++; if (flush_o !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b exp 0", flush_o); end
`ifdef FETCH_PERF_EN
        vectors++; if (fetch_cnt_o !== 32'h0 || redir_cnt_o !== 32'h0) begin miscompares++; $display("FAIL reset_cnt: got %h/%h exp 0/0", fetch_cnt_o, redir_cnt_o); end
`endif
        // Release, then the BOOT cycle must hold request low.
        @(negedge clk); rstn = 1'b0; imem_ack_i = 1'b1; #1;
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL boot_req: got %b exp 0", imem_req_o); end
        tick();
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
            vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(k * 4)) begin miscompares++; $display("FAIL stream_req: got %b/%h exp 1/%h", imem_req_o, imem_addr_o, 32'(k * 4)); end
            tick();
            vectors++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'(k * 4) || if_instr_o !== m_instr) begin miscompares++; $display("FAIL stream_slot: got %b/%h/%h exp 1/%h/%h", if_valid_o, if_pc_o, if_instr_o, 32'(k * 4), m_instr); end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
            vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL stall_req: got %b exp 0", imem_req_o); end
            tick();
            vectors++; if (if_pc_o !== 32'h8 || pc_o !== 32'hC || if_valid_o !== 1'b1) begin miscompares++; $display("FAIL stall_hold: got %h/%h/%b exp 00000008/0000000c/1", if_pc_o, pc_o, if_valid_o); end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin miscompares++; $display("FAIL stall_resume: got %b/%h exp 1/0000000c", imem_req_o, imem_addr_o); end
        tick();
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b1, 32'h0000_0103, 1'b1, 32'hDEAD_BEEF);
        tick();
        vectors++; if (flush_o !== 1'b1 || if_valid_o !== 1'b0 || pc_o !== 32'h100 || if_instr_o !== NOP) begin miscompares++; $display("FAIL redir_apply: got %b/%b/%h/%h exp 1/0/00000100/%h", flush_o, if_valid_o, pc_o, if_instr_o, NOP); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL redir_bubble: got %b exp 0", imem_req_o); end
        tick();
        vectors++; if (flush_o !== 1'b0) begin miscompares++; $display("FAIL redir_flush_len: got %b exp 0", flush_o); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin miscompares++; $display("FAIL redir_refetch: got %b/%h exp 1/00000100", imem_req_o, imem_addr_o); end
        tick();
    endtask

    task automatic test_back_to_back();
`ifdef FETCH_PERF_EN
        logic [31:0] r0 = redir_cnt_o;
`endif
        drive(1'b0, 1'b1, 32'h40, 1'b1, $urandom);
        tick();
        vectors++; if (flush_o !== 1'b1 || pc_o !== 32'h40) begin miscompares++; $display("FAIL b2b_first: got %b/%h exp 1/00000040", flush_o, pc_o); end
        drive(1'b0, 1'b1, 32'h80, 1'b1, $urandom);
        tick();
        vectors++; if (flush_o !== 1'b1 || pc_o !== 32'h80) begin miscompares++; $display("FAIL b2b_second: got %b/%h exp 1/00000080", flush_o, pc_o); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL b2b_bubble: got %b exp 0", imem_req_o); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h80) begin miscompares++; $display("FAIL b2b_fetch: got %b/%h exp 1/00000080", imem_req_o, imem_addr_o); end
        tick();
`ifdef FETCH_PERF_EN
        vectors++; if (redir_cnt_o - r0 !== 32'd2) begin miscompares++; $display("FAIL b2b_redir_cnt: got %0d exp 2", redir_cnt_o - r0); end
`endif
    endtask

    task automatic test_wrap();
`ifdef FETCH_PERF_EN
        logic [31:0] f0;
`endif
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
`ifdef FETCH_PERF_EN
        f0 = fetch_cnt_o;
`endif
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        vectors++; if (imem_addr_o !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr_o); end
        tick();
        vectors++; if (pc_o !== 32'h0 || if_pc_o !== 32'hFFFF_FFFC || if_instr_o !== 32'h1234_5678) begin miscompares++; $display("FAIL wrap_pc: got %h/%h/%h exp 00000000/fffffffc/12345678", pc_o, if_pc_o, if_instr_o); end
`ifdef FETCH_PERF_EN
        vectors++; if (fetch_cnt_o - f0 !== 32'd1) begin miscompares++; $display("FAIL wrap_fetch_cnt: got %0d exp 1", fetch_cnt_o - f0); end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 10) < 3, ($urandom % 12) == 0, $urandom, ($urandom % 10) < 7, $urandom);
            vectors++; if (imem_req_o !== m_req() || (m_req() && imem_addr_o !== m_pc)) begin miscompares++; $display("FAIL rand_req: got %b/%h exp %b/%h", imem_req_o, imem_addr_o, m_req(), m_pc); end
            tick();
            vectors++;
            if ({pc_o, if_valid_o, if_pc_o, if_instr_o, flush_o} !== {m_pc, m_valid, m_ipc, m_instr, m_flush}) begin
                miscompares++;
                $display("FAIL rand_state: got pc=%h v=%b ipc=%h ins=%h fl=%b exp pc=%h v=%b ipc=%h ins=%h fl=%b",
                         pc_o, if_valid_o, if_pc_o, if_instr_o, flush_o, m_pc, m_valid, m_ipc, m_instr, m_flush);
            end
`ifdef FETCH_PERF_EN
            vectors++; if (fetch_cnt_o !== m_fcnt || redir_cnt_o !== m_rcnt) begin miscompares++; $display("FAIL rand_cnt: got %h/%h exp %h/%h", fetch_cnt_o, redir_cnt_o, m_fcnt, m_rcnt); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        repeat (2) begin drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); tick(); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        vectors++; if (imem_req_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_req: got %b exp 1", imem_req_o); end
        rstn = 1'b1; model_reset(); #1;
        vectors++; if (imem_req_o !== 1'b0 || pc_o !== 32'h0 || if_instr_o !== NOP || if_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_async: got %b/%h/%h/%b exp 0/00000000/%h/0", imem_req_o, pc_o, if_instr_o, if_valid_o, NOP); end
        tick();
        vectors++; if (pc_o !== 32'h0 || if_valid_o !== 1'b0 || flush_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_hold: got %h/%b/%b exp 00000000/0/0", pc_o, if_valid_o, flush_o); end
        @(negedge clk); rstn = 1'b0; #1;
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_boot: got %b exp 0", imem_req_o); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin miscompares++; $display("FAIL rstmid_first: got %b/%h exp 1/00000000", imem_req_o, imem_addr_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
